// File: rtl/mux_pkg.sv
// Shared constants and lock FSM encoding for the 4-to-1 round-robin stream mux.
package mux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    Idle   = 1'b0,
    Locked = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Round-robin grant for four requesters; a lock pins the grant to lock_ch.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  input  logic              lock,
  input  logic [SEL_W-1:0]  lock_ch,
  output logic [NUM_CH-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_req
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = '0;
    // Search starts just past the previous winner and wraps 3 -> 0.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_grant + SEL_W'(k);
      if (!found && req[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
    if (lock) begin
      grant_idx = lock_ch;
    end
    any_req      = lock ? req[lock_ch] : (|req);
    grant_onehot = NUM_CH'(1) << grant_idx;
  end

endmodule

// File: rtl/rr_mux4to1_stream.sv
// 4-to-1 valid/ready merge with round-robin arbitration and a registered output stage.
// Define RR_MUX_PACKET_LOCK_EN to hold the grant on one channel until in_last.
module rr_mux4to1_stream
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef RR_MUX_PACKET_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  last_grant_q;
  logic [NUM_CH-1:0] grant_onehot;
  logic [SEL_W-1:0]  grant_idx;
  logic              any_req;
  logic              lock;
  logic [SEL_W-1:0]  lock_ch;
  logic              free;
  logic              accept;
  logic [WIDTH-1:0]  grant_data;

  rr_arbiter4 u_arb (
    .req          (in_valid),
    .last_grant   (last_grant_q),
    .lock         (lock),
    .lock_ch      (lock_ch),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_req      (any_req)
  );

  assign free     = !out_valid || out_ready;
  assign accept   = free && any_req && !rst;
  assign in_ready = accept ? grant_onehot : '0;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sel      <= '0;
      last_grant_q <= 2'b11;
    end else if (free) begin
      out_valid <= any_req;
      if (any_req) begin
        out_data     <= grant_data;
        out_sel      <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

`ifdef RR_MUX_PACKET_LOCK_EN
  lock_state_e      state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    unique case (state_q)
      Idle: begin
        if (accept && !in_last[grant_idx]) begin
          state_d   = Locked;
          lock_ch_d = grant_idx;
        end
      end
      Locked: begin
        if (accept && in_last[grant_idx]) begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= Idle;
      lock_ch_q <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      if (free) begin
        out_last <= any_req && in_last[grant_idx];
      end
    end
  end

  assign lock    = (state_q == Locked);
  assign lock_ch = lock_ch_q;
`else
  assign lock    = 1'b0;
  assign lock_ch = '0;
`endif

endmodule

// File: tb/tb_rr_mux4to1_stream.sv
// Directed self-checking bench for rr_mux4to1_stream (lock steps only with RR_MUX_PACKET_LOCK_EN).
module tb_rr_mux4to1_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic [7:0]  d [4];
`ifdef RR_MUX_PACKET_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign in_data = {d[3], d[2], d[1], d[0]};

  rr_mux4to1_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_MUX_PACKET_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output beat packed as {valid, sel, data}.
  function automatic logic [31:0] beat(input logic v, input logic [1:0] s, input logic [7:0] dd);
    return {21'd0, v, s, dd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
`ifdef RR_MUX_PACKET_LOCK_EN
    in_last = 4'hF;
`endif
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel", {30'd0, out_sel}, 32'd0);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_grant", {28'd0, in_ready}, 32'h1);

    // Fair rotation at full throughput.
    step(); check("rot0", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'hA0));
    step(); check("rot1", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd1, 8'hA1));
    step(); check("rot2", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd2, 8'hA2));
    step(); check("rot3", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd3, 8'hA3));
    step(); check("rot4", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'hA0));

    // Backpressure: 5C is held while ch2 keeps offering 5D.
    in_valid = 4'b0100; d[2] = 8'h5C;
    step(); check("load_5c", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd2, 8'h5C));
    d[2] = 8'h5D; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {28'd0, in_ready}, 32'h0);
      step();
      check("stall_hold", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd2, 8'h5C));
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {28'd0, in_ready}, 32'h4);
    step(); check("next_5d", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd2, 8'h5D));
    in_valid = 4'b0000;
    step(); check("drain_idle", {31'd0, out_valid}, 32'd0);

    // Pointer at 1: ch3 beats ch0, then ch0 follows.
    in_valid = 4'b0010; d[1] = 8'hB1;
    step(); check("ch1_single", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd1, 8'hB1));
    in_valid = 4'b1001; d[0] = 8'hC0; d[3] = 8'hC3;
    #1;
    check("wrap_grant3", {28'd0, in_ready}, 32'h8);
    step(); check("wrap_out3", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd3, 8'hC3));
    check("wrap_grant0", {28'd0, in_ready}, 32'h1);
    step(); check("wrap_out0", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'hC0));

    // Reset while holding 77 (pointer at 0 before reset).
    in_valid = 4'b0001; d[0] = 8'h77;
    step(); check("load_77", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'h77));
    in_valid = 4'b0000; out_ready = 1'b0;
    step(); check("hold_77", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'h77));
    rst = 1'b1;
    step(); check("rst_mid", beat(out_valid, out_sel, out_data), beat(1'b0, 2'd0, 8'h00));
    rst = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
    #1;
    check("rst_ptr", {28'd0, in_ready}, 32'h1);
    step(); check("rst_first", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'hA0));

`ifdef RR_MUX_PACKET_LOCK_EN
    // Pointer at 0: ch1 packet 11,12,13 holds off ch0.
    in_valid = 4'b0011; d[0] = 8'hE0; d[1] = 8'h11; in_last = 4'b0001;
    step(); check("pkt_11", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd1, 8'h11));
    check("pkt_last11", {31'd0, out_last}, 32'd0);
    d[1] = 8'h12;
    step(); check("pkt_12", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd1, 8'h12));
    check("pkt_last12", {31'd0, out_last}, 32'd0);
    d[1] = 8'h13; in_last = 4'b0011;
    step(); check("pkt_13", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd1, 8'h13));
    check("pkt_last13", {31'd0, out_last}, 32'd1);
    in_valid = 4'b0001;
    step(); check("pkt_after", beat(out_valid, out_sel, out_data), beat(1'b1, 2'd0, 8'hE0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
